// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and helpers for the backing-RAM port arbiter.
// Holds the default address width, the arbiter state enum and a width helper.
package ram_port_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index/counter width for n distinct values, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle between the cache controllers, the arbiter and the RAM model.
// master = requester/RAM side, slave = arbiter.
interface ram_port_arbiter_if
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = DEF_ADDR_W
);
    localparam int unsigned ID_W = clog2_min1(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ-1:0]        ready;
    logic                      ram_req;
    logic [ADDR_W-1:0]         ram_address;
    logic                      ram_ready;
    logic                      grant_valid;
    logic [ID_W-1:0]           grant_id;
    logic                      timeout_err;

    modport master (
        output req, req_address, ram_ready,
        input  ready, ram_req, ram_address, grant_valid, grant_id, timeout_err
    );

    modport slave (
        input  req, req_address, ram_ready,
        output ready, ram_req, ram_address, grant_valid, grant_id, timeout_err
    );

endinterface

// File: rtl/ram_port_arbiter_rr_pick.sv
// Round-robin winner select: first set request bit at or after i_ptr, wrapping.
module ram_port_arbiter_rr_pick
    import ram_port_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [ID_W-1:0]    o_winner,
    output logic               o_any
);

    logic        w_found;
    int unsigned w_idx;

    // Walk ptr, ptr+1, ... modulo NUM_REQ; first hit wins.
    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = (32'(i_ptr) + k) % NUM_REQ;
            if (!w_found && i_req[ID_W'(w_idx)]) begin
                w_found  = 1'b1;
                o_winner = ID_W'(w_idx);
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one backing-RAM port among NUM_REQ cache controllers, round-robin,
// holding the grant for a whole access, with a sticky access-timeout flag.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    ram_port_arbiter_if.slave bus
);

    localparam int unsigned      ID_W    = clog2_min1(NUM_REQ);
    localparam int unsigned      WD_W    = clog2_min1(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic             WD_EN   = (TIMEOUT != 0);

    arb_state_e        r_state;
    logic [ID_W-1:0]   r_grant_id;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [WD_W-1:0]   r_wd_cnt;
    logic              r_timeout_err;

    logic [ID_W-1:0]   w_winner;
    logic              w_any;
    logic              w_req_g;
    logic              w_done;
    logic [ID_W-1:0]   w_ptr_next;
    logic [ADDR_W-1:0] w_addr_arr [NUM_REQ];
    logic [NUM_REQ-1:0] w_ready;
    logic              w_ram_req;
    logic [ADDR_W-1:0] w_ram_address;
    logic              w_grant_valid;

    ram_port_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req    (bus.req),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
        assign w_addr_arr[gi] = bus.req_address[gi*ADDR_W +: ADDR_W];
    end

    assign w_req_g    = bus.req[r_grant_id];
    // Completion wins over a simultaneous request drop; both release the port.
    assign w_done     = bus.ram_ready || !w_req_g;
    assign w_ptr_next = (r_grant_id == LAST_ID) ? '0 : r_grant_id + ID_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant_id <= w_winner;
                        r_wd_cnt   <= '0;
                        r_state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (WD_EN && (r_wd_cnt == WD_MAX) && !bus.ram_ready) begin
                        r_timeout_err <= 1'b1;
                    end
                    if (r_wd_cnt != WD_MAX) begin
                        r_wd_cnt <= r_wd_cnt + WD_W'(1);
                    end
                    if (w_done) begin
                        r_rr_ptr <= w_ptr_next;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Port mux: the owner's request passes straight through while granted.
    always_comb begin
        w_ready       = '0;
        w_ram_req     = 1'b0;
        w_ram_address = '0;
        w_grant_valid = 1'b0;
        if (r_state == GRANT) begin
            w_grant_valid        = 1'b1;
            w_ram_req            = w_req_g;
            w_ram_address        = w_addr_arr[r_grant_id];
            w_ready[r_grant_id]  = bus.ram_ready;
        end
    end

    assign bus.ready       = w_ready;
    assign bus.ram_req     = w_ram_req;
    assign bus.ram_address = w_ram_address;
    assign bus.grant_valid = w_grant_valid;
    assign bus.grant_id    = r_grant_id;
    assign bus.timeout_err = r_timeout_err;

endmodule
